// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART frame transmitter: start, LSB-first data, optional parity, stop bit(s)
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous reset, active-high; aborts any frame in progress
//   tx_data  - byte to send, captured in the accept cycle only
//   tx_valid - producer offers tx_data
//   tx_ready - block accepts a byte this cycle (IDLE and not in reset)
//   tx       - registered serial line, idles high
//   tx_busy  - frame in progress
//   tx_done  - single-cycle pulse in the cycle the block returns to IDLE

module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           state;
    logic [CW-1:0]        cyc_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 bit_end;

    assign bit_end  = (cyc_cnt == CYC_LAST);
    assign tx_ready = (state == S_IDLE) & ~rst;
    assign tx_busy  = (state != S_IDLE);

    // tx is driven from a register: each transition loads the level of the
    // bit that starts on the next cycle, so the line never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            tx_done <= 1'b0;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state == S_IDLE) begin
                cyc_cnt <= '0;
                bit_cnt <= '0;
                if (tx_valid) begin
                    shreg   <= tx_data;
                    // Parity is fixed at accept time from the latched byte.
                    par_bit <= (^tx_data) ^ (PARITY_ODD != 0);
                    state   <= S_START;
                    tx      <= 1'b0;
                end
            end else begin
                cyc_cnt <= bit_end ? '0 : cyc_cnt + CW'(1);
                if (bit_end) begin
                    case (state)
                        S_START: begin
                            state <= S_DATA;
                            tx    <= shreg[0];
                        end
                        S_DATA: begin
                            shreg <= shreg >> 1;
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
                                if (PARITY_EN != 0) begin
                                    state <= S_PARITY;
                                    tx    <= par_bit;
                                end else begin
                                    state <= S_STOP;
                                    tx    <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                                // shreg[1] is the bit that becomes shreg[0] after this shift.
                                tx      <= shreg[1];
                            end
                        end
                        S_PARITY: begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end
                        S_STOP: begin
                            if (bit_cnt == STOP_LAST) begin
                                bit_cnt <= '0;
                                state   <= S_IDLE;
                                tx_done <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end
                        default: begin
                            state <= S_IDLE;
                            tx    <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx across four parameter sets

module tb_uart_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic [3:0] tx_valid;
    wire  [3:0] tx_ready;
    wire  [3:0] tx_line;
    wire  [3:0] tx_busy;
    wire  [3:0] tx_done;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    // d0: no parity, 1 stop; d1: even parity; d2: odd parity; d3: 2 stop bits
    uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .tx(tx_line[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));
    uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .tx(tx_line[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));
    uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
        .tx(tx_line[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));
    uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[3]), .tx_ready(tx_ready[3]),
        .tx(tx_line[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]));

    function automatic int par_en_of(int d);
        return (d == 1 || d == 2) ? 1 : 0;
    endfunction

    function automatic int odd_of(int d);
        return (d == 2) ? 1 : 0;
    endfunction

    function automatic int stop_of(int d);
        return (d == 3) ? 2 : 1;
    endfunction

    function automatic int frame_bits(int d);
        return 1 + 8 + par_en_of(d) + stop_of(d);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(int d, logic [7:0] b);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        if (par_en_of(d) != 0) exp_q.push_back((^b) ^ (odd_of(d) != 0));
        for (int i = 0; i < stop_of(d); i++) exp_q.push_back(1'b1);
    endtask

    // Offers b to DUT d and advances through the accept edge; tx_valid stays high.
    task automatic start_frame(int d, logic [7:0] b);
        tx_data     = b;
        tx_valid[d] = 1'b1;
        push_frame(d, b);
        tick();
    endtask

    // Walks cycles T+1 .. T+N*C of the frame, then checks the tx_done cycle.
    task automatic check_frame(int d, bit change, logic [7:0] nd, bit pulse);
        int nc;
        bit exp;
        nc = frame_bits(d) * C;
        for (int c = 1; c <= nc; c++) begin
            if (c == 12) begin
                if (change) tx_data = nd;
                if (pulse) tx_valid[d] = 1'b1;
            end
            if (c == 13 && pulse) tx_valid[d] = 1'b0;
            exp = (exp_q.size() != 0) ? exp_q[0] : 1'b1;
            n_checks++;
            if (tx_line[d] !== exp) begin
                n_fail++;
                $display("FAIL tx_bit d%0d T+%0d: got %b want %b", d, c, tx_line[d], exp);
            end
            n_checks++;
            if ({tx_busy[d], tx_ready[d], tx_done[d]} !== 3'b100) begin
                n_fail++;
                $display("FAIL frame_status d%0d T+%0d: busy/ready/done got %b want 100",
                         d, c, {tx_busy[d], tx_ready[d], tx_done[d]});
            end
            if (c % C == 0 && exp_q.size() != 0) void'(exp_q.pop_front());
            tick();
        end
        n_checks++;
        if ({tx_line[d], tx_busy[d], tx_ready[d], tx_done[d]} !== 4'b1011) begin
            n_fail++;
            $display("FAIL done_cycle d%0d T+%0d: tx/busy/ready/done got %b want 1011",
                     d, nc + 1, {tx_line[d], tx_busy[d], tx_ready[d], tx_done[d]});
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain d%0d: got %0d bits left want 0", d, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        tx_valid = 4'b0;
        tx_data  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({tx_line, tx_busy, tx_done, tx_ready} !== {4'hF, 4'h0, 4'h0, 4'h0}) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: tx/busy/done/ready got %h want f000",
                         i, {tx_line, tx_busy, tx_done, tx_ready});
            end
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if ({tx_line, tx_busy, tx_done, tx_ready} !== {4'hF, 4'h0, 4'h0, 4'hF}) begin
            n_fail++;
            $display("FAIL reset_release: tx/busy/done/ready got %h want f00f",
                     {tx_line, tx_busy, tx_done, tx_ready});
        end
    endtask

    task automatic test_single();
        start_frame(0, 8'hA5);
        tx_valid[0] = 1'b0;
        check_frame(0, 1'b0, 8'h00, 1'b0);
        tick();
    endtask

    task automatic test_back_to_back();
        start_frame(0, 8'h00);
        check_frame(0, 1'b1, 8'hFF, 1'b0);
        // tx_valid still high in the done cycle: second byte accepted here.
        push_frame(0, 8'hFF);
        tick();
        tx_valid[0] = 1'b0;
        check_frame(0, 1'b0, 8'h00, 1'b0);
        tick();
    endtask

    task automatic test_parity();
        start_frame(1, 8'h03);
        tx_valid[1] = 1'b0;
        check_frame(1, 1'b0, 8'h00, 1'b0);
        tick();
        start_frame(2, 8'h03);
        tx_valid[2] = 1'b0;
        check_frame(2, 1'b0, 8'h00, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid();
        start_frame(0, 8'h00);
        tx_valid[0] = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        n_checks++;
        if (tx_line[0] !== 1'b0 || tx_busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_frame_bit3: tx/busy got %b%b want 01", tx_line[0], tx_busy[0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({tx_line[0], tx_busy[0], tx_done[0]} !== 3'b100) begin
            n_fail++;
            $display("FAIL abort: tx/busy/done got %b want 100", {tx_line[0], tx_busy[0], tx_done[0]});
        end
        exp_q.delete();
        for (int i = 0; i < 30; i++) begin
            tick();
            n_checks++;
            if ({tx_line[0], tx_busy[0], tx_done[0], tx_ready[0]} !== 4'b1001) begin
                n_fail++;
                $display("FAIL post_abort cyc%0d: tx/busy/done/ready got %b want 1001",
                         i, {tx_line[0], tx_busy[0], tx_done[0], tx_ready[0]});
            end
        end
        start_frame(0, 8'h5A);
        tx_valid[0] = 1'b0;
        check_frame(0, 1'b0, 8'h00, 1'b0);
        tick();
    endtask

    task automatic test_isolation();
        start_frame(3, 8'hC3);
        tx_valid[3] = 1'b0;
        check_frame(3, 1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if ({tx_line[3], tx_busy[3], tx_ready[3]} !== 3'b101) begin
                n_fail++;
                $display("FAIL no_second_frame cyc%0d: tx/busy/ready got %b want 101",
                         i, {tx_line[3], tx_busy[3], tx_ready[3]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_reset_mid();
        test_isolation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial transmitter (UART framing) that drives a single-wire line. Its output is sampled at the far end by flip-flop-based receive logic. It accepts a parallel byte over a valid/ready handshake, then shifts it out LSB-first. The frame is a start bit, data bits, an optional parity bit and stop bit(s), with each bit held for a fixed number of clock cycles. It sits between core logic producing bytes and the board-level TX pin.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range >= 2
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous reset, active-high
tx_data  input  DATA_BITS  byte to send; sampled only in the accept cycle
tx_valid  input  1  producer has data on tx_data
tx_ready  output  1  block can accept a byte this cycle
tx  output  1  serial line, registered, idles high
tx_busy  output  1  frame in progress (any state other than IDLE)
tx_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset: clk and rst are fixed as decided: one clock, synchronous active-high reset.
  - While rst=1 at a clk edge, the next state is IDLE, tx=1, tx_busy=0, tx_done=0.
  - The bit counter, cycle counter and shift register are cleared.
  - tx_ready = (state==IDLE) & ~rst, so tx_ready=0 while rst is high and 1 from the first cycle after release.
- Handshake:
  - A byte is accepted in cycle T iff tx_valid=1 and tx_ready=1 at the edge ending T.
  - tx_data is latched into the shift register at that edge.
  - Later changes to tx_data have no effect on the frame.
  - tx_valid while busy is ignored; no queuing.
- Frame length N = 1 + DATA_BITS + PARITY_EN + STOP_BITS bits.
- FSM states IDLE, START, DATA, PARITY, STOP:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY after DATA_BITS bits when PARITY_EN=1, otherwise DATA -> STOP.
  - PARITY -> STOP after one bit.
  - STOP -> IDLE after STOP_BITS bits.
- tx value per state:
  - START: tx=0.
  - DATA: tx = shift register bit 0, LSB first; shift right once per bit.
  - PARITY: tx = XOR of all latched data bits, XOR PARITY_ODD.
  - STOP: tx=1.
  - IDLE: tx=1.
- Timing:
  - Start bit is on tx from cycle T+1.
  - Every bit is held exactly CLKS_PER_BIT cycles.
  - The block is back in IDLE at cycle T+1+N*CLKS_PER_BIT. In that cycle tx_done=1 (single cycle), tx_ready=1 and tx_busy=0.
- Back-to-back:
  - If tx_valid=1 in the tx_done cycle, the byte is accepted there and its start bit begins on the next cycle.
  - There is no extra idle gap beyond the stop bit(s).
- Cycle counter: 0..CLKS_PER_BIT-1, sized $clog2(CLKS_PER_BIT); wraps to 0 at each bit boundary.
- Bit counter: sized to hold DATA_BITS-1.
- Reset mid-frame: the frame is aborted.
  - tx=1 from the cycle after the rst edge.
  - No tx_done pulse; the latched byte is discarded.
- Illegal parameter values: out of scope; the bench uses only legal values.

Test Plan:
- Reset/idle (CLKS_PER_BIT=4, DATA_BITS=8): assert rst 3 cycles then release -> tx=1, tx_busy=0, tx_done=0 throughout; tx_ready=0 during rst, 1 afterwards.
- Single frame 0xA5 (no parity, 1 stop, accept at T):
  - tx per 4-cycle bit from T+1: 0, 1,0,1,0,0,1,0,1, 1.
  - tx_busy=1 over T+1..T+40; tx_done=1 only at T+41.
- Back-to-back: tx_valid held high with 0x00 then 0xFF -> second accept in the tx_done cycle (T+41); second start bit at T+42; tx_ready high for exactly one cycle between frames.
- Parity: 0x03 with PARITY_EN=1:
  - PARITY_ODD=0 -> parity bit 0; PARITY_ODD=1 -> parity bit 1.
  - 11-bit frame; tx_done at T+45.
- Reset mid-frame: assert rst during data bit 3 -> tx=1 next cycle; no tx_done pulse; after release the next byte 0x5A transmits correctly.
- Input isolation: change tx_data and pulse tx_valid during a frame of 0xC3 -> transmitted bits remain those of 0xC3; no second frame starts; STOP_BITS=2 case holds tx=1 for 8 cycles.
